// File: rtl/pc_gen.sv
// Fetch-PC register and next-PC generator with MEM-stage redirect, flush and fetch bubble.
// Optional performance counters are built when PERF_CNT_EN is defined.
`ifndef NPC_PLUS4
`define NPC_PLUS4  3'd0
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH 3'd1
`endif
`ifndef NPC_JUMP
`define NPC_JUMP   3'd2
`endif
`ifndef NPC_JALR
`define NPC_JALR   3'd3
`endif

module pc_gen #(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_PC      = 32'h0000_3000,
  parameter int               INC           = 4,
  parameter int               REDIR_BUBBLES = 1,
  parameter int               CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       redir_op,
  input  logic [WIDTH-1:0] redir_pc,
  input  logic [WIDTH-1:0] redir_imm,
  input  logic [WIDTH-1:0] redir_rs1,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] redir_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int SH = (INC > 1) ? $clog2(INC) : 0;
  localparam logic [WIDTH-1:0] LOW =
    WIDTH'((64'd1 << SH) - 64'd1);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    BUBBLE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n;
  logic             valid_n;
  logic [2:0]       bcnt, bcnt_n;
  logic             is_redir;
  logic             taken;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] tgt;

  always_comb begin
    is_redir = 1'b0;
    raw      = redir_pc + redir_imm;
    case (redir_op)
      `NPC_BRANCH,
      `NPC_JUMP: is_redir = 1'b1;
      `NPC_JALR: begin
        is_redir = 1'b1;
        raw      = (redir_rs1 + redir_imm) &
                   ~WIDTH'(1);
      end
      default: is_redir = 1'b0;
    endcase
  end

  // BOOT and reset mask the redirect so nothing is flushed before the first fetch
  assign taken    = is_redir && !rst &&
                    (state != BOOT);
  assign tgt      = raw & ~LOW;
  assign flush    = taken;
  assign misalign = taken && (|(raw & LOW));

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = pc_valid;
    bcnt_n  = bcnt;
    if (state == BOOT) begin
      state_n = RUN;
      valid_n = 1'b1;
    end else if (taken) begin
      pc_n = tgt;
      if (REDIR_BUBBLES > 0) begin
        state_n = BUBBLE;
        valid_n = 1'b0;
        bcnt_n  = 3'(REDIR_BUBBLES);
      end else begin
        state_n = RUN;
        valid_n = 1'b1;
      end
    end else if (state == BUBBLE) begin
      if (bcnt <= 3'd1) begin
        state_n = RUN;
        valid_n = 1'b1;
        bcnt_n  = 3'd0;
      end else begin
        bcnt_n = bcnt - 3'd1;
      end
    end else if (!stall) begin
      pc_n = pc + WIDTH'(INC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      bcnt     <= 3'd0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pc_valid <= valid_n;
      bcnt     <= bcnt_n;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] rc, sc;
  logic             stall_run;

  assign stall_run = (state == RUN) && stall &&
                     !taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc <= '0;
      sc <= '0;
    end else begin
      if (taken && !(&rc))
        rc <= rc + CNT_W'(1);
      if (stall_run && !(&sc))
        sc <= sc + CNT_W'(1);
    end
  end

  assign redir_cnt = rc;
  assign stall_cnt = sc;
`else
  assign redir_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver queues per-cycle expectations,
// monitor checks them on the falling edge. Covers REDIR_BUBBLES=1 and 3.
module tb_pc_gen;

  localparam logic [2:0] P4 = 3'd0;
  localparam logic [2:0] BR = 3'd1;
  localparam logic [2:0] JP = 3'd2;
  localparam logic [2:0] JR = 3'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  redir_op = 3'd0;
  logic [31:0] redir_pc = '0;
  logic [31:0] redir_imm = '0;
  logic [31:0] redir_rs1 = '0;

  logic [31:0] pc1, pc3, rc1, rc3, sc1, sc3;
  logic        v1, v3, fl1, fl3, mi1, mi3;

  typedef struct {
    logic        sel;
    logic [31:0] pc;
    logic        v;
    logic        fl;
    logic        mis;
    logic [31:0] rc;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int er = 0;
  int es = 0;
  bit done = 1'b0;

  pc_gen u1 (
    .clk(clk), .rst(rst), .stall(stall),
    .redir_op(redir_op), .redir_pc(redir_pc),
    .redir_imm(redir_imm), .redir_rs1(redir_rs1),
    .pc(pc1), .pc_valid(v1), .flush(fl1),
    .misalign(mi1), .redir_cnt(rc1),
    .stall_cnt(sc1)
  );

  pc_gen #(.REDIR_BUBBLES(3)) u3 (
    .clk(clk), .rst(rst), .stall(stall),
    .redir_op(redir_op), .redir_pc(redir_pc),
    .redir_imm(redir_imm), .redir_rs1(redir_rs1),
    .pc(pc3), .pc_valid(v3), .flush(fl3),
    .misalign(mi3), .redir_cnt(rc3),
    .stall_cnt(sc3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk("pc", pc1, e.pc);
          chk("pc_valid", 32'(v1), 32'(e.v));
          chk("flush", 32'(fl1), 32'(e.fl));
          chk("misalign", 32'(mi1), 32'(e.mis));
          chk("redir_cnt", rc1, e.rc);
          chk("stall_cnt", sc1, e.sc);
        end else begin
          chk("pc_b3", pc3, e.pc);
          chk("pc_valid_b3", 32'(v3), 32'(e.v));
          chk("flush_b3", 32'(fl3), 32'(e.fl));
          chk("misalign_b3", 32'(mi3), 32'(e.mis));
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic st,
                     input logic [2:0] op,
                     input logic [31:0] rpc,
                     input logic [31:0] imm,
                     input logic [31:0] rs1,
                     input logic [31:0] epc,
                     input logic ev, input logic efl,
                     input logic emis, input logic sel);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    stall     = st;
    redir_op  = op;
    redir_pc  = rpc;
    redir_imm = imm;
    redir_rs1 = rs1;
    if (r) begin
      er = 0;
      es = 0;
    end
    e.sel = sel;
    e.pc  = epc;
    e.v   = ev;
    e.fl  = efl;
    e.mis = emis;
`ifdef PERF_CNT_EN
    e.rc  = 32'(er);
    e.sc  = 32'(es);
`else
    e.rc  = '0;
    e.sc  = '0;
`endif
    q.push_back(e);
    if (!r && !sel) begin
      if (efl) er++;
      if (st && !efl && ev) es++;
    end
  endtask

  initial begin
    // reset, redirect on the bus must not flush
    cyc(1,0,BR,0,0,0, 32'h3000,0,0,0,0);
    cyc(1,0,BR,0,0,0, 32'h3000,0,0,0,0);
    cyc(0,0,BR,0,8,0, 32'h3000,0,0,0,0);
    cyc(0,0,P4,0,0,0, 32'h3000,1,0,0,0);
    cyc(0,0,P4,0,0,0, 32'h3004,1,0,0,0);
    // stall 3 cycles at 0x3008
    cyc(0,1,P4,0,0,0, 32'h3008,1,0,0,0);
    cyc(0,1,P4,0,0,0, 32'h3008,1,0,0,0);
    cyc(0,1,P4,0,0,0, 32'h3008,1,0,0,0);
    cyc(0,0,P4,0,0,0, 32'h3008,1,0,0,0);
    // branch overrides stall, one bubble
    cyc(0,1,BR,32'h3004,32'h10,0,
        32'h300C,1,1,0,0);
    cyc(0,0,P4,0,0,0, 32'h3014,0,0,0,0);
    cyc(0,0,P4,0,0,0, 32'h3014,1,0,0,0);
    // JALR aligned and misaligned
    cyc(0,0,JR,0,0,32'h4001,
        32'h3018,1,1,0,0);
    cyc(0,0,P4,0,0,0, 32'h4000,0,0,0,0);
    cyc(0,0,JR,0,0,32'h4002,
        32'h4000,1,1,1,0);
    cyc(0,0,P4,0,0,0, 32'h4000,0,0,0,0);
    cyc(0,0,P4,0,0,0, 32'h4000,1,0,0,0);
    // jump to top of address space, then wrap
    cyc(0,0,JP,32'hFFFF_FFF0,32'hC,0,
        32'h4004,1,1,0,0);
    cyc(0,0,P4,0,0,0, 32'hFFFF_FFFC,0,0,0,0);
    cyc(0,0,P4,0,0,0, 32'hFFFF_FFFC,1,0,0,0);
    cyc(0,0,P4,0,0,0, 32'h0000_0000,1,0,0,0);
    // negative immediate
    cyc(0,0,BR,32'h100,32'hFFFF_FFF8,0,
        32'h4,1,1,0,0);
    cyc(0,0,P4,0,0,0, 32'hF8,0,0,0,0);
    // unknown op behaves as PLUS4
    cyc(0,0,3'd5,32'h777,1,0, 32'hF8,1,0,0,0);
    cyc(0,1,P4,0,0,0, 32'hFC,1,0,0,0);
    // reset mid-stall
    cyc(1,1,P4,0,0,0, 32'h3000,0,0,0,0);
    // REDIR_BUBBLES=3 instance
    cyc(0,0,P4,0,0,0, 32'h3000,0,0,0,1);
    cyc(0,0,P4,0,0,0, 32'h3000,1,0,0,1);
    cyc(0,0,JP,32'h5000,32'h20,0,
        32'h3004,1,1,0,1);
    cyc(0,0,P4,0,0,0, 32'h5020,0,0,0,1);
    cyc(0,0,P4,0,0,0, 32'h5020,0,0,0,1);
    cyc(0,0,BR,32'h6000,32'h4,0,
        32'h5020,0,1,0,1);
    cyc(0,0,P4,0,0,0, 32'h6004,0,0,0,1);
    cyc(0,0,P4,0,0,0, 32'h6004,0,0,0,1);
    cyc(0,1,P4,0,0,0, 32'h6004,0,0,0,1);
    cyc(0,1,P4,0,0,0, 32'h6004,1,0,0,1);
    cyc(0,0,P4,0,0,0, 32'h6004,1,0,0,1);
    cyc(0,0,BR,32'h200,32'h6,0,
        32'h6008,1,1,1,1);
    cyc(0,0,P4,0,0,0, 32'h204,0,0,0,1);
    // reset mid-bubble
    cyc(1,0,P4,0,0,0, 32'h3000,0,0,0,1);
    done = 1'b1;
  end

  initial begin
    wait (done);
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d left, need 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
